barrel_shifter_arb: RTL and testbench
=====================================

BARREL_SHIFTER_ARB -- requirements
Module: barrel_shifter_arb

Interface
REQ-001 Parameter CNT_W, default 8, width of the completed-operation counter.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_req0_valid / i_req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 i_req0_A / i_req1_A  input  8  operand of requester 0/1.
REQ-006 i_req0_k / i_req1_k  input  3  rotate amount of requester 0/1.
REQ-007 o_req0_ready / o_req1_ready  output  1  operation accepted this cycle (grant); one-cycle pulse.
REQ-008 o_rsp_valid  output  1  result available.
REQ-009 o_rsp_Y  output  8  rotated result.
REQ-010 o_rsp_id  output  1  requester that owns o_rsp_Y.
REQ-011 i_rsp_ready  input  1  consumer accepts the result when high with o_rsp_valid.
REQ-012 o_busy  output  1  high in any state other than IDLE.
REQ-013 o_done_cnt  output  CNT_W  number of completed responses.

Function
REQ-014 Rotation semantics SHALL be o_rsp_Y[i] = A[(i+k) mod 8] (rotate toward LSB by k); k=0 passes A unchanged.
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; one operation in flight at a time.
REQ-016 IDLE: if any valid is high, grant exactly one requester, pulse its ready, capture its A, k, id into operand registers, go to EXEC; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: a priority pointer (reset 0) selects the winner when both valids are high; after each grant the pointer points to the non-granted requester.
REQ-018 A single valid requester SHALL be granted regardless of the pointer; the pointer still updates per REQ-017.
REQ-019 EXEC: rotator output from the captured operands is registered into o_rsp_Y/o_rsp_id, o_rsp_valid set, go to RESP; grant-to-valid latency is exactly 2 cycles.
REQ-020 RESP: o_rsp_valid, o_rsp_Y, o_rsp_id SHALL hold stable until i_rsp_ready is high; on that cycle o_rsp_valid clears next edge, o_done_cnt increments, FSM returns to IDLE.
REQ-021 No ready SHALL pulse outside IDLE; a requester must hold valid and operands until its ready pulse.
REQ-022 A response handshake and a new grant SHALL NOT occur in the same cycle; back-to-back throughput is one operation per 3 cycles with i_rsp_ready held high.
REQ-023 o_done_cnt SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-024 Valid deasserted in EXEC/RESP SHALL have no effect on the in-flight operation.

Reset
REQ-025 With i_rst high at an edge: FSM to IDLE, pointer 0, o_rsp_valid 0, o_rsp_Y 0, o_rsp_id 0, o_done_cnt 0, readies 0, o_busy 0.
REQ-026 Reset mid-operation SHALL discard the in-flight operation without a response and without incrementing o_done_cnt.

Configuration
REQ-027 Macro BSA_ROTL_EN: when defined, ports i_req0_dir / i_req1_dir (input 1) exist and are captured with the operands; dir=1 rotates toward MSB by k, applied as effective amount (8-k) mod 8.
REQ-028 When BSA_ROTL_EN is undefined the dir ports are absent and all operations rotate per REQ-014.

Structure
REQ-029 Shared package SHALL hold FSM state encoding (IDLE/EXEC/RESP), requester id constants, and data width 8 / amount width 3.
REQ-030 Datapath SHALL be one instance of the existing 8-bit barrel_shifter sub-module fed from the operand registers; no other sub-module.

Verification
REQ-031 Req0 only, A=0x81, k=1 -> ready0 pulse, o_rsp_valid 2 cycles later, Y=0xC0, id=0, o_done_cnt=1.
REQ-032 Both valid from reset, A0=0x0F k0=4, A1=0x01 k1=3 -> req0 served first (Y=0xF0), then req1 (Y=0x20), alternating thereafter.
REQ-033 i_rsp_ready low 5 cycles in RESP -> Y/id stable, no ready pulses, o_busy high; accepted on first high cycle.
REQ-034 i_rst asserted in EXEC -> next cycle o_rsp_valid 0, o_done_cnt unchanged at 0, IDLE.
REQ-035 CNT_W=2, 4 completions -> o_done_cnt 1,2,3,0.
REQ-036 BSA_ROTL_EN, A=0x81, k=1, dir=1 -> Y=0x03; dir=0 -> Y=0xC0.

Source files
------------

// File: rtl/barrel_shifter_arb_pkg.sv
// Shared definitions for the barrel_shifter_arb slice: FSM state encoding,
// requester id constants, and datapath widths (8-bit data, 3-bit amount).
package barrel_shifter_arb_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/barrel_shifter.sv
// 8-bit logarithmic rotator: y[i] = a[(i+k) mod 8], i.e. rotate toward LSB by k.
module barrel_shifter
    import barrel_shifter_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [AMT_W-1:0]  k,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;

    // Three mux stages, rotating by 1, 2 and 4 under control of k[0], k[1], k[2].
    always_comb begin
        s1 = k[0] ? {a[0],    a[7:1]}  : a;
        s2 = k[1] ? {s1[1:0], s1[7:2]} : s1;
        y  = k[2] ? {s2[3:0], s2[7:4]} : s2;
    end

endmodule

// File: rtl/barrel_shifter_arb.sv
// Two-requester round-robin front end for a single 8-bit rotator.
// One operation in flight: IDLE (grant) -> EXEC (rotate) -> RESP (hold result).
// Optional feature: define BSA_ROTL_EN to add per-requester dir ports;
// dir=1 rotates toward MSB by k (implemented as an LSB rotation by (8-k) mod 8).
module barrel_shifter_arb
    import barrel_shifter_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    input  logic [DATA_W-1:0] i_req0_A,
    input  logic [AMT_W-1:0]  i_req0_k,
    input  logic              i_req1_valid,
    input  logic [DATA_W-1:0] i_req1_A,
    input  logic [AMT_W-1:0]  i_req1_k,
`ifdef BSA_ROTL_EN
    input  logic              i_req0_dir,
    input  logic              i_req1_dir,
`endif
    output logic              o_req0_ready,
    output logic              o_req1_ready,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_Y,
    output logic              o_rsp_id,
    input  logic              i_rsp_ready,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_done_cnt
);

    state_t            state_q;
    state_t            state_d;
    logic              rr_ptr_q;
    logic              grant0;
    logic              grant1;
    logic              rsp_fire;

    logic [DATA_W-1:0] op_a_p0;
    logic [AMT_W-1:0]  op_k_p0;
    logic              op_id_p0;
    logic [AMT_W-1:0]  rot_k;
    logic [DATA_W-1:0] rot_y;

`ifdef BSA_ROTL_EN
    logic              op_dir_p0;
`endif

    assign rsp_fire     = (state_q == ST_RESP) && i_rsp_ready;
    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;
    assign o_busy       = (state_q != ST_IDLE);

    // Next-state and grant decode; grants only in IDLE and never while in reset.
    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!i_rst) begin
                    if (i_req0_valid && i_req1_valid) begin
                        grant0 = (rr_ptr_q == REQ_ID0);
                        grant1 = (rr_ptr_q == REQ_ID1);
                    end else begin
                        grant0 = i_req0_valid;
                        grant1 = i_req1_valid;
                    end
                end
                if (grant0 || grant1) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Round-robin pointer: after a grant it points at the requester that lost.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q <= REQ_ID0;
        end else if (grant0) begin
            rr_ptr_q <= REQ_ID1;
        end else if (grant1) begin
            rr_ptr_q <= REQ_ID0;
        end
    end

    // ---- stage p0: operand capture at grant ----
    // Operand registers are data only; they are qualified by the FSM state.
    always_ff @(posedge i_clk) begin
        if (grant0) begin
            op_a_p0  <= i_req0_A;
            op_k_p0  <= i_req0_k;
            op_id_p0 <= REQ_ID0;
`ifdef BSA_ROTL_EN
            op_dir_p0 <= i_req0_dir;
`endif
        end else if (grant1) begin
            op_a_p0  <= i_req1_A;
            op_k_p0  <= i_req1_k;
            op_id_p0 <= REQ_ID1;
`ifdef BSA_ROTL_EN
            op_dir_p0 <= i_req1_dir;
`endif
        end
    end

`ifdef BSA_ROTL_EN
    // Left rotation by k equals right rotation by (8-k) mod 8, i.e. -k in 3 bits.
    assign rot_k = op_dir_p0 ? (3'd0 - op_k_p0) : op_k_p0;
`else
    assign rot_k = op_k_p0;
`endif

    barrel_shifter u_rot (
        .a (op_a_p0),
        .k (rot_k),
        .y (rot_y)
    );

    // ---- stage p1: result register, loaded in EXEC and held through RESP ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_Y     <= '0;
            o_rsp_id    <= REQ_ID0;
        end else if (state_q == ST_EXEC) begin
            o_rsp_valid <= 1'b1;
            o_rsp_Y     <= rot_y;
            o_rsp_id    <= op_id_p0;
        end else if (rsp_fire) begin
            o_rsp_valid <= 1'b0;
        end
    end

    // Completed-response counter; wraps silently.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_done_cnt <= '0;
        end else if (rsp_fire) begin
            o_done_cnt <= o_done_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_barrel_shifter_arb.sv
// Directed table-driven bench for barrel_shifter_arb, plus hand sequences for
// response back-pressure and mid-operation reset. A second instance with
// CNT_W=2 shares all inputs so the counter wrap is observed alongside.
module tb_barrel_shifter_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_a, req1_a;
    logic [2:0] req0_k, req1_k;
    logic       req0_dir, req1_dir;
    logic       rsp_ready;

    logic       ready0, ready1, rsp_valid, rsp_id, busy;
    logic [7:0] rsp_y;
    logic [7:0] done_cnt;

    logic       w_ready0, w_ready1, w_rsp_valid, w_rsp_id, w_busy;
    logic [7:0] w_rsp_y;
    logic [1:0] w_done_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    barrel_shifter_arb #(.CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .i_req0_A     (req0_a),
        .i_req0_k     (req0_k),
        .i_req1_valid (req1_valid),
        .i_req1_A     (req1_a),
        .i_req1_k     (req1_k),
`ifdef BSA_ROTL_EN
        .i_req0_dir   (req0_dir),
        .i_req1_dir   (req1_dir),
`endif
        .o_req0_ready (ready0),
        .o_req1_ready (ready1),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_Y      (rsp_y),
        .o_rsp_id     (rsp_id),
        .i_rsp_ready  (rsp_ready),
        .o_busy       (busy),
        .o_done_cnt   (done_cnt)
    );

    barrel_shifter_arb #(.CNT_W(2)) dut_w (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .i_req0_A     (req0_a),
        .i_req0_k     (req0_k),
        .i_req1_valid (req1_valid),
        .i_req1_A     (req1_a),
        .i_req1_k     (req1_k),
`ifdef BSA_ROTL_EN
        .i_req0_dir   (req0_dir),
        .i_req1_dir   (req1_dir),
`endif
        .o_req0_ready (w_ready0),
        .o_req1_ready (w_ready1),
        .o_rsp_valid  (w_rsp_valid),
        .o_rsp_Y      (w_rsp_y),
        .o_rsp_id     (w_rsp_id),
        .i_rsp_ready  (rsp_ready),
        .o_busy       (w_busy),
        .o_done_cnt   (w_done_cnt)
    );

    typedef struct {
        logic       v0;
        logic [7:0] a0;
        logic [2:0] k0;
        logic       d0;
        logic       v1;
        logic [7:0] a1;
        logic [2:0] k1;
        logic       d1;
        logic       exp_id;
        logic [7:0] exp_y;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One complete transaction from an idle DUT, response accepted immediately.
    task automatic run_txn(input string nm,
                           input logic v0, input logic [7:0] a0, input logic [2:0] k0, input logic d0,
                           input logic v1, input logic [7:0] a1, input logic [2:0] k1, input logic d1,
                           input logic exp_id, input logic [7:0] exp_y);
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_k = k0; req0_dir = d0;
        req1_valid = v1; req1_a = a1; req1_k = k1; req1_dir = d1;
        rsp_ready  = 1'b0;
        #1;
        chk({nm, " ready0"}, 32'(ready0), 32'(exp_id == 1'b0));
        chk({nm, " ready1"}, 32'(ready1), 32'(exp_id == 1'b1));
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({nm, " exec_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, " exec_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, " Y"}, 32'(rsp_y), 32'(exp_y));
        chk({nm, " id"}, 32'(rsp_id), 32'(exp_id));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt++;
        chk({nm, " valid_clr"}, 32'(rsp_valid), 32'd0);
        chk({nm, " idle_busy"}, 32'(busy), 32'd0);
        chk({nm, " cnt"}, 32'(done_cnt), 32'(exp_cnt % 256));
        chk({nm, " cnt_w2"}, 32'(w_done_cnt), 32'(exp_cnt % 4));
    endtask

    initial begin
        // Pointer starts at 0: both-valid vectors alternate 0,1,0.
        vecs[0] = '{1'b1, 8'h0F, 3'd4, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0, 1'b0, 8'hF0};
        vecs[1] = '{1'b1, 8'h0F, 3'd4, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0, 1'b1, 8'h20};
        vecs[2] = '{1'b1, 8'h0F, 3'd4, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0, 1'b0, 8'hF0};
        // Pointer now 1; single requester 0 still wins.
        vecs[3] = '{1'b1, 8'h81, 3'd1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'hC0};
        vecs[4] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h3C, 3'd2, 1'b0, 1'b1, 8'h0F};
        // Pointer now 0; single requester 1 still wins.
        vecs[5] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'hA5, 3'd0, 1'b0, 1'b1, 8'hA5};
        vecs[6] = '{1'b1, 8'h80, 3'd7, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h01};
        // Pointer now 1: requester 1 wins the tie.
        vecs[7] = '{1'b1, 8'h12, 3'd0, 1'b0, 1'b1, 8'h96, 3'd5, 1'b0, 1'b1, 8'hB4};
        vecs[8] = '{1'b1, 8'hFE, 3'd1, 1'b0, 1'b1, 8'h11, 3'd2, 1'b0, 1'b0, 8'h7F};

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = 8'h00; req0_k = 3'd0; req0_dir = 1'b0;
        req1_valid = 1'b0; req1_a = 8'h00; req1_k = 3'd0; req1_dir = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst Y", 32'(rsp_y), 32'd0);
        chk("rst id", 32'(rsp_id), 32'd0);
        chk("rst cnt", 32'(done_cnt), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ready0", 32'(ready0), 32'd0);
        chk("rst ready1", 32'(ready1), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i),
                    vecs[i].v0, vecs[i].a0, vecs[i].k0, vecs[i].d0,
                    vecs[i].v1, vecs[i].a1, vecs[i].k1, vecs[i].d1,
                    vecs[i].exp_id, vecs[i].exp_y);
        end

`ifdef BSA_ROTL_EN
        run_txn("rotl_dir1", 1'b1, 8'h81, 3'd1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h03);
        run_txn("rotl_dir0", 1'b1, 8'h81, 3'd1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'hC0);
`endif

        // Back-pressure: response held 5 cycles while requesters keep asking.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h81; req0_k = 3'd1; req0_dir = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        #1;
        chk("hold grant0", 32'(ready0), 32'd1);
        @(negedge clk);
        req0_a = 8'h55; req0_k = 3'd3;
        req1_valid = 1'b1; req1_a = 8'h33; req1_k = 3'd1;
        chk("hold exec ready0", 32'(ready0), 32'd0);
        chk("hold exec ready1", 32'(ready1), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("hold%0d Y", i), 32'(rsp_y), 32'hC0);
            chk($sformatf("hold%0d id", i), 32'(rsp_id), 32'd0);
            chk($sformatf("hold%0d ready0", i), 32'(ready0), 32'd0);
            chk($sformatf("hold%0d ready1", i), 32'(ready1), 32'd0);
            chk($sformatf("hold%0d busy", i), 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("hold cnt_before", 32'(done_cnt), 32'(exp_cnt % 256));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt++;
        chk("hold accepted valid", 32'(rsp_valid), 32'd0);
        chk("hold accepted cnt", 32'(done_cnt), 32'(exp_cnt % 256));
        chk("hold accepted busy", 32'(busy), 32'd0);

        // Reset while in EXEC: operation discarded, counter cleared, pointer back to 0.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h81; req0_k = 3'd1;
        #1;
        chk("rstexec grant0", 32'(ready0), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("rstexec in_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        chk("rstexec rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstexec busy", 32'(busy), 32'd0);
        chk("rstexec cnt", 32'(done_cnt), 32'd0);
        @(negedge clk);
        chk("rstexec no_late_valid", 32'(rsp_valid), 32'd0);
        run_txn("post_rst", 1'b1, 8'h0F, 3'd4, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0, 1'b0, 8'hF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
